// File: rtl/uart_rx_sequencer.sv
// UART receiver: 2-flop RxD synchronizer, oversampled mid-bit sampling, optional parity, single holding register.
// Latency: Dout/RxRDY/status update on the same edge that samples the stop bit (0 cycles after that BaudTick edge).
// Backpressure: none on the line; an unread frame plus a new one sets Overrun and drops the new frame.
module uart_rx_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 BaudTick,
  input  logic                 RxD,
  input  logic                 RD,
  output logic [DATA_BITS-1:0] Dout,
  output logic                 RxRDY,
  output logic                 ParityErr,
  output logic                 FramingErr,
  output logic                 Overrun,
  output logic                 Idle
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(7);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          HAS_PAR  = (PARITY_EN != 0);
  localparam logic          ODD      = (ODD_PARITY != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_cap;
  logic                 rxd_meta;
  logic                 rxd_s;
  logic                 load;

  // Frame completes on the stop-bit sampling tick.
  assign load = BaudTick && (state == S_STOP) && (cnt == CNT_LAST);
  assign Idle = (state == S_IDLE);

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_s    <= rxd_meta;
    end
  end

  // Frame sequencer: counters move only on BaudTick.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      perr_cap <= 1'b0;
    end else if (BaudTick) begin
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_MID) begin
            // Mid start bit: still low means a real frame, high means a glitch.
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            shift   <= {rxd_s, shift[DATA_BITS-1:1]};
            cnt     <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state <= HAS_PAR ? S_PARITY : S_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            perr_cap <= (^shift) ^ rxd_s ^ ODD;
            cnt      <= '0;
            state    <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end else if (state > S_STOP) begin
      // Illegal encodings recover without waiting for a tick.
      state <= S_IDLE;
    end
  end

  // Holding register and status; a load beats a simultaneous read.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Dout       <= '0;
      RxRDY      <= 1'b0;
      ParityErr  <= 1'b0;
      FramingErr <= 1'b0;
      Overrun    <= 1'b0;
    end else if (load) begin
      if (RxRDY && !RD) begin
        Overrun <= 1'b1;
      end else begin
        Dout       <= shift;
        RxRDY      <= 1'b1;
        FramingErr <= !rxd_s;
        ParityErr  <= HAS_PAR ? perr_cap : 1'b0;
        Overrun    <= 1'b0;
      end
    end else if (RD && RxRDY) begin
      RxRDY      <= 1'b0;
      ParityErr  <= 1'b0;
      FramingErr <= 1'b0;
      Overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: serial frames built bit by bit, flags checked against hand-computed values.
// BaudTick pulses every second clock, so cycles without a tick are always exercised.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_rx_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       BaudTick = 1'b0;
  logic       RxD = 1'b1;
  logic       RD = 1'b0;
  logic [7:0] Dout;
  logic       RxRDY;
  logic       ParityErr;
  logic       FramingErr;
  logic       Overrun;
  logic       Idle;

  int checks = 0;
  int errors = 0;

  uart_rx_sequencer #(
    .OVERSAMPLE(16),
    .DATA_BITS (8),
    .PARITY_EN (1),
    .ODD_PARITY(0)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .BaudTick  (BaudTick),
    .RxD       (RxD),
    .RD        (RD),
    .Dout      (Dout),
    .RxRDY     (RxRDY),
    .ParityErr (ParityErr),
    .FramingErr(FramingErr),
    .Overrun   (Overrun),
    .Idle      (Idle)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One baud tick lasting one clock, followed by one clock without a tick.
  task automatic baud(input logic rd);
    @(negedge Clock);
    BaudTick = 1'b1;
    RD = rd;
    @(negedge Clock);
    BaudTick = 1'b0;
    RD = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    repeat (16) baud(1'b0);
  endtask

  // Full frame; the stop bit is sampled on tick 9 of its period, where RD may be asserted.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input logic rd_at_load, input string tag);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par);
    RxD = stop;
    for (int i = 0; i < 16; i++) begin
      baud((i == 9) ? rd_at_load : 1'b0);
      if (i == 9) chk({tag, "_rdy_at_stop_edge"}, 32'(RxRDY), 32'd1);
    end
    RxD = 1'b1;
    repeat (16) baud(1'b0);
  endtask

  task automatic read_pulse;
    @(negedge Clock);
    RD = 1'b1;
    @(negedge Clock);
    RD = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_dout", 32'(Dout), 32'h0);
    chk("rst_rdy", 32'(RxRDY), 32'd0);
    chk("rst_flags", {29'd0, ParityErr, FramingErr, Overrun}, 32'd0);
    chk("rst_idle", 32'(Idle), 32'd1);
    repeat (4) baud(1'b0);

    // 0xA5, even parity bit 0, good stop
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, "a5");
    chk("a5_dout", 32'(Dout), 32'hA5);
    chk("a5_flags", {29'd0, ParityErr, FramingErr, Overrun}, 32'd0);
    chk("a5_idle", 32'(Idle), 32'd1);
    read_pulse();
    chk("a5_rd_clears", 32'(RxRDY), 32'd0);
    read_pulse();
    chk("rd_when_empty_dout", 32'(Dout), 32'hA5);
    chk("rd_when_empty_rdy", 32'(RxRDY), 32'd0);

    // Start-bit glitch: low for 4 ticks only
    RxD = 1'b0;
    repeat (4) baud(1'b0);
    chk("glitch_in_start", 32'(Idle), 32'd0);
    RxD = 1'b1;
    repeat (12) baud(1'b0);
    chk("glitch_idle", 32'(Idle), 32'd1);
    chk("glitch_rdy", 32'(RxRDY), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, "3c");
    chk("3c_dout", 32'(Dout), 32'h3C);
    chk("3c_flags", {29'd0, ParityErr, FramingErr, Overrun}, 32'd0);
    read_pulse();

    // Parity error: 0x01 needs parity 1 for even
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, "01");
    chk("01_dout", 32'(Dout), 32'h01);
    chk("01_perr", {29'd0, ParityErr, FramingErr, Overrun}, 32'h4);
    read_pulse();
    chk("01_rd_clears_perr", {28'd0, RxRDY, ParityErr, FramingErr, Overrun}, 32'd0);

    // Framing error: 0x55 with stop bit 0
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, "55");
    chk("55_dout", 32'(Dout), 32'h55);
    chk("55_ferr", {28'd0, RxRDY, ParityErr, FramingErr, Overrun}, 32'hA);
    read_pulse();

    // Overrun: 0x11 then 0x22 unread
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, "11");
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, "22ov");
    chk("ov_dout", 32'(Dout), 32'h11);
    chk("ov_flags", {28'd0, RxRDY, ParityErr, FramingErr, Overrun}, 32'h9);
    read_pulse();
    chk("ov_rd_clears", {28'd0, RxRDY, ParityErr, FramingErr, Overrun}, 32'd0);

    // Same pair, RD on the 0x22 load edge: load wins
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, "11b");
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, "22rd");
    chk("rdload_dout", 32'(Dout), 32'h22);
    chk("rdload_flags", {28'd0, RxRDY, ParityErr, FramingErr, Overrun}, 32'h8);
    read_pulse();

    // Reset after 4th data bit of a frame
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("partial_busy", 32'(Idle), 32'd0);
    repeat (20) @(negedge Clock);
    chk("partial_hold_no_tick", 32'(Idle), 32'd0);
    Reset = 1'b1;
    BaudTick = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    BaudTick = 1'b0;
    RxD = 1'b1;
    chk("midrst_idle", 32'(Idle), 32'd1);
    chk("midrst_dout", 32'(Dout), 32'h0);
    chk("midrst_flags", {28'd0, RxRDY, ParityErr, FramingErr, Overrun}, 32'd0);
    repeat (16) baud(1'b0);
    chk("midrst_no_output", 32'(RxRDY), 32'd0);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0, "7e");
    chk("7e_dout", 32'(Dout), 32'h7E);
    chk("7e_flags", {28'd0, RxRDY, ParityErr, FramingErr, Overrun}, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
